// File: rtl/pr_bridge.sv
// pr_bridge: processor-port bridge between the multi-cycle MIPS core and up to six devices.
// Decodes each request, holds it until ready or timeout, and synchronises device interrupts.
module pr_bridge #(
    parameter int              NDEV          = 4,
    parameter logic [31:0]     BASE          = 32'h0000_7F00,
    parameter int              DEV_SPAN_LOG2 = 4,
    parameter int              TIMEOUT       = 15,
    parameter logic [NDEV-1:0] IRQ_EDGE      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PrReq,
    input  logic                     PrWe,
    input  logic [29:0]              PrAddr,
    input  logic [31:0]              PrWD,
    input  logic [3:0]               BE,
    output logic [31:0]              PrRD,
    output logic                     PrAck,
    output logic                     PrErr,
    output logic [NDEV-1:0]          DevSel,
    output logic [DEV_SPAN_LOG2-3:0] DevAddr,
    output logic [31:0]              DevWD,
    output logic [3:0]               DevBE,
    output logic                     DevWe,
    input  logic [NDEV*32-1:0]       DevRD,
    input  logic [NDEV-1:0]          DevRdy,
    input  logic [NDEV-1:0]          DevIrq,
    output logic [5:0]               HWInt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [31:0]              rd_q, rd_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [NDEV-1:0]          sel_q, sel_d;
    logic [DEV_SPAN_LOG2-3:0] addr_q, addr_d;
    logic [31:0]              wd_q, wd_d;
    logic [3:0]               be_q, be_d;
    logic                     we_q, we_d;

    logic [31:0]              byteAddr;
    logic [31:0]              offset;
    logic [31:0]              slot;
    logic                     hit;
    logic [NDEV-1:0]          reqSel;
    logic                     selRdy;
    logic [31:0]              selRd;

    logic [NDEV-1:0]          sync1_q, sync2_q, syncPrev_q;
    logic [NDEV-1:0]          edgePend_q, edgePend_d;
    logic [NDEV-1:0]          clrVec;
    logic [NDEV-1:0]          pend;
    logic [5:0]               hwInt_q, hwInt_d;

    // Address decode of the incoming request and mux of the latched device's ready/data.
    always_comb begin
        byteAddr = {PrAddr, 2'b00};
        offset   = byteAddr - BASE;
        slot     = offset >> DEV_SPAN_LOG2;
        hit      = (byteAddr >= BASE) && (slot < 32'(NDEV));
        reqSel   = '0;
        selRdy   = 1'b0;
        selRd    = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (slot == 32'(i)) begin
                reqSel[i] = 1'b1;
            end
            if (idx_q == 3'(i)) begin
                selRdy = DevRdy[i];
                selRd  = DevRD[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (PrReq) begin
                    if (hit) begin
                        state_d = ACCESS;
                        idx_d   = slot[2:0];
                        cnt_d   = '0;
                        sel_d   = reqSel;
                        addr_d  = byteAddr[DEV_SPAN_LOG2-1:2];
                        wd_d    = PrWD;
                        be_d    = BE;
                        we_d    = PrWe;
                    end else begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rd_d    = '0;
                        sel_d   = '0;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                // Ready wins over a timeout landing in the same cycle.
                if (selRdy) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    rd_d    = we_q ? 32'd0 : selRd;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rd_d    = '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            we_q    <= we_d;
        end
    end

    // Edge-mode pending bits clear when a successful access to that device responds; a new edge wins.
    always_comb begin
        clrVec     = '0;
        edgePend_d = '0;
        pend       = '0;
        hwInt_d    = '0;
        for (int i = 0; i < NDEV; i++) begin
            clrVec[i]     = (state_q == RESP) && !err_q && (idx_q == 3'(i));
            edgePend_d[i] = (sync2_q[i] & ~syncPrev_q[i]) | (edgePend_q[i] & ~clrVec[i]);
            pend[i]       = IRQ_EDGE[i] ? edgePend_q[i] : sync2_q[i];
            hwInt_d[i]    = pend[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            syncPrev_q <= '0;
            edgePend_q <= '0;
            hwInt_q    <= '0;
        end else begin
            sync1_q    <= DevIrq;
            sync2_q    <= sync1_q;
            syncPrev_q <= sync2_q;
            edgePend_q <= edgePend_d;
            hwInt_q    <= hwInt_d;
        end
    end

    assign PrRD    = rd_q;
    assign PrAck   = ack_q;
    assign PrErr   = err_q;
    assign DevSel  = sel_q;
    assign DevAddr = addr_q;
    assign DevWD   = wd_q;
    assign DevBE   = be_q;
    assign DevWe   = we_q;
    assign HWInt   = hwInt_q;

endmodule

// File: tb/tb_pr_bridge.sv
// tb_pr_bridge: transaction-level model of pr_bridge checked every cycle, with directed
// scenarios for latency, timeout, decode miss, interrupts and mid-access reset plus random traffic.
`timescale 1ns/1ps
module tb_pr_bridge;

    localparam int          NDEV     = 4;
    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam int          SPAN     = 4;
    localparam int          TO       = 15;
    localparam logic [3:0]  EDGEMASK = 4'b0100;

    logic         clk;
    logic         rst;
    logic         PrReq;
    logic         PrWe;
    logic [29:0]  PrAddr;
    logic [31:0]  PrWD;
    logic [3:0]   BE;
    logic [31:0]  PrRD;
    logic         PrAck;
    logic         PrErr;
    logic [3:0]   DevSel;
    logic [1:0]   DevAddr;
    logic [31:0]  DevWD;
    logic [3:0]   DevBE;
    logic         DevWe;
    logic [127:0] DevRD;
    logic [3:0]   DevRdy;
    logic [3:0]   DevIrq;
    logic [5:0]   HWInt;

    pr_bridge #(
        .NDEV(NDEV), .BASE(BASE), .DEV_SPAN_LOG2(SPAN), .TIMEOUT(TO), .IRQ_EDGE(EDGEMASK)
    ) dut (
        .clk(clk), .rst(rst), .PrReq(PrReq), .PrWe(PrWe), .PrAddr(PrAddr), .PrWD(PrWD), .BE(BE),
        .PrRD(PrRD), .PrAck(PrAck), .PrErr(PrErr), .DevSel(DevSel), .DevAddr(DevAddr),
        .DevWD(DevWD), .DevBE(DevBE), .DevWe(DevWe), .DevRD(DevRD), .DevRdy(DevRdy),
        .DevIrq(DevIrq), .HWInt(HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nTests = 0;
    int          nFails = 0;
    bit          irqRandom = 0;
    logic [31:0] devData [4];
    logic [5:0]  lastHw;

    logic        expAck = 0;
    logic        expErr = 0;
    logic [31:0] expRd = 0;
    logic [3:0]  expSel = 0;
    logic        expWe = 0;
    logic [1:0]  expAddr = 0;
    logic [31:0] expWD = 0;
    logic [3:0]  expBE = 0;
    int          expIdx = -1;

    logic [3:0]  irqD1, irqD2, irqD3, irqD4, pendPrev, clrPrev, pendNow, clrNow, expHw4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setExpIdle();
        expAck = 0; expErr = 0; expRd = 0; expSel = 0; expWe = 0; expIdx = -1;
    endtask

    task automatic driveIrq();
        if (irqRandom) begin
            for (int i = 0; i < NDEV; i++) begin
                if ($urandom_range(7) == 0) DevIrq[i] = ~DevIrq[i];
            end
        end
    endtask

    task automatic loadDevData();
        DevRD = {devData[3], devData[2], devData[1], devData[0]};
    endtask

    task automatic idleCycle();
        PrReq  = 0;
        PrAddr = 30'($urandom);
        PrWD   = $urandom;
        PrWe   = 1'($urandom);
        BE     = 4'($urandom);
        DevRdy = 4'($urandom);
        driveIrq();
        setExpIdle();
        @(negedge clk);
        lastHw = HWInt;
        @(posedge clk);
        #1;
    endtask

    // One processor transaction; the model derives latency and result from the decode and wait count.
    task automatic applyStimulus(input logic [29:0] addr, input logic we, input logic [31:0] wd,
                                 input logic [3:0] be, input int w, input bit pulse2,
                                 input int abortK, output int obsAck, output logic obsErr,
                                 output logic [31:0] obsRd, output logic [3:0] obsSel1,
                                 output logic [1:0] obsAddr1, output int weCount);
        logic [31:0] byteA;
        logic        hit;
        logic        timedOut;
        logic        errM;
        logic [31:0] rdM;
        logic [3:0]  rdyBits;
        int          idx;
        int          done;
        int          ackK;
        byteA    = {addr, 2'b00};
        hit      = (byteA >= BASE) && (byteA < BASE + 32'(NDEV * 16));
        idx      = hit ? int'((byteA - BASE) / 16) : 0;
        timedOut = hit && (w > TO - 1);
        done     = !hit ? 0 : (timedOut ? TO : 1 + w);
        ackK     = done + 1;
        errM     = !hit || timedOut;
        rdM      = (!errM && !we) ? devData[idx] : 32'd0;
        obsAck = -1; obsErr = 0; obsRd = 0; obsSel1 = 0; obsAddr1 = 0; weCount = 0;
        for (int k = 0; k <= ackK; k++) begin
            if (k == 0) begin
                PrReq = 1; PrAddr = addr; PrWe = we; PrWD = wd; BE = be;
            end else begin
                PrReq = 1'($urandom); PrAddr = 30'($urandom); PrWe = 1'($urandom);
                PrWD = $urandom; BE = 4'($urandom);
            end
            rdyBits = 4'($urandom);
            if (hit) rdyBits[idx] = (k >= 1 + w);
            DevRdy = rdyBits;
            driveIrq();
            if (pulse2) DevIrq[2] = (k == 0);
            expAck  = (k == ackK);
            expErr  = errM;
            expRd   = rdM;
            expSel  = (hit && k >= 1 && k <= done) ? 4'(1 << idx) : 4'd0;
            expWe   = (expSel != 0) && we;
            expAddr = byteA[3:2];
            expWD   = wd;
            expBE   = be;
            expIdx  = hit ? idx : -1;
            if (k == abortK) begin
                #2 rst = 0;
                setExpIdle();
                #1;
                check("async reset DevSel", 32'(DevSel), 32'd0);
                check("async reset DevWe", 32'(DevWe), 32'd0);
                repeat (2) idleCycle();
                rst = 1;
                PrReq = 0;
                return;
            end
            @(negedge clk);
            if (PrAck === 1'b1 && obsAck < 0) begin
                obsAck = k; obsErr = PrErr; obsRd = PrRD;
            end
            if (k == 1) begin
                obsSel1 = DevSel; obsAddr1 = DevAddr;
            end
            if (DevWe === 1'b1) weCount++;
            @(posedge clk);
            #1;
        end
        PrReq = 0;
        setExpIdle();
    endtask

    // Per-cycle comparison of every output against the model; interrupts follow input history.
    initial begin : compare
        irqD1 = 0; irqD2 = 0; irqD3 = 0; irqD4 = 0; pendPrev = 0; clrPrev = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("reset PrAck", 32'(PrAck), 32'd0);
                check("reset PrErr", 32'(PrErr), 32'd0);
                check("reset PrRD", PrRD, 32'd0);
                check("reset DevSel", 32'(DevSel), 32'd0);
                check("reset DevAddr", 32'(DevAddr), 32'd0);
                check("reset DevWD", DevWD, 32'd0);
                check("reset DevBE", 32'(DevBE), 32'd0);
                check("reset DevWe", 32'(DevWe), 32'd0);
                check("reset HWInt", 32'(HWInt), 32'd0);
                irqD1 = 0; irqD2 = 0; irqD3 = 0; irqD4 = 0; pendPrev = 0; clrPrev = 0;
            end else begin
                check("PrAck", 32'(PrAck), 32'(expAck));
                if (expAck) begin
                    check("PrErr", 32'(PrErr), 32'(expErr));
                    check("PrRD", PrRD, expRd);
                end
                check("DevSel", 32'(DevSel), 32'(expSel));
                check("DevWe", 32'(DevWe), 32'(expWe));
                if (expSel != 0) begin
                    check("DevAddr", 32'(DevAddr), 32'(expAddr));
                    check("DevWD", DevWD, expWD);
                    check("DevBE", 32'(DevBE), 32'(expBE));
                end
                pendNow = ((irqD3 & ~irqD4) | (pendPrev & ~clrPrev)) & EDGEMASK;
                expHw4  = (EDGEMASK & pendPrev) | (~EDGEMASK & irqD3);
                check("HWInt", 32'(HWInt), 32'({2'b00, expHw4}));
                for (int i = 0; i < NDEV; i++) begin
                    clrNow[i] = expAck && !expErr && (expIdx == i);
                end
                pendPrev = pendNow;
                clrPrev  = clrNow;
                irqD4 = irqD3; irqD3 = irqD2; irqD2 = irqD1; irqD1 = DevIrq;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int          obsAck;
        int          weCount;
        logic        obsErr;
        logic [31:0] obsRd;
        logic [3:0]  obsSel1;
        logic [1:0]  obsAddr1;
        logic [31:0] byteA;
        int          w;

        rst = 1; PrReq = 0; PrWe = 0; PrAddr = 0; PrWD = 0; BE = 0;
        DevRdy = 0; DevIrq = 0; DevRD = 0;
        for (int i = 0; i < NDEV; i++) devData[i] = $urandom;
        #1 rst = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (2) idleCycle();

        devData[1] = 32'hCAFEF00D;
        loadDevData();
        applyStimulus(30'h1FC4, 1'b0, 32'h0, 4'hF, 0, 0, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        check("read1 ack cycle", 32'(obsAck), 32'd2);
        check("read1 err", 32'(obsErr), 32'd0);
        check("read1 data", obsRd, 32'hCAFEF00D);
        check("read1 DevSel", 32'(obsSel1), 32'b0010);
        idleCycle();

        applyStimulus(30'h1FC9, 1'b1, 32'h12345678, 4'b0011, 3, 0, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        check("write ack cycle", 32'(obsAck), 32'd5);
        check("write DevAddr", 32'(obsAddr1), 32'd1);
        check("write DevWe cycles", 32'(weCount), 32'd4);
        check("write PrRD", obsRd, 32'd0);

        applyStimulus(30'h1FC0, 1'b0, 32'h0, 4'hF, 100, 0, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        check("timeout ack cycle", 32'(obsAck), 32'd16);
        check("timeout err", 32'(obsErr), 32'd1);
        check("timeout PrRD", obsRd, 32'd0);
        devData[3] = 32'h3333_0003;
        loadDevData();
        applyStimulus(30'h1FCC, 1'b0, 32'h0, 4'hF, 2, 0, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        check("after timeout ack cycle", 32'(obsAck), 32'd4);
        check("after timeout data", obsRd, 32'h3333_0003);

        applyStimulus(30'h1FD0, 1'b0, 32'h0, 4'hF, 0, 0, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        check("miss high ack cycle", 32'(obsAck), 32'd1);
        check("miss high err", 32'(obsErr), 32'd1);
        applyStimulus(30'h1FBF, 1'b1, 32'h55, 4'hF, 0, 0, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        check("miss low ack cycle", 32'(obsAck), 32'd1);
        check("miss low err", 32'(obsErr), 32'd1);
        repeat (3) idleCycle();

        DevIrq[2] = 1;
        idleCycle();
        DevIrq[2] = 0;
        repeat (3) idleCycle();
        check("edge irq at +3", 32'(lastHw[2]), 32'd0);
        idleCycle();
        check("edge irq at +4", 32'(lastHw[2]), 32'd1);
        idleCycle();
        applyStimulus(30'h1FC8, 1'b0, 32'h0, 4'hF, 0, 1, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        repeat (3) idleCycle();
        check("edge set wins over clear", 32'(lastHw[2]), 32'd1);
        applyStimulus(30'h1FC8, 1'b0, 32'h0, 4'hF, 0, 0, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        repeat (2) idleCycle();
        check("edge cleared by read", 32'(lastHw[2]), 32'd0);

        DevIrq[0] = 1;
        idleCycle();
        repeat (2) idleCycle();
        check("level irq at +2", 32'(lastHw[0]), 32'd0);
        idleCycle();
        check("level irq at +3", 32'(lastHw[0]), 32'd1);
        DevIrq[0] = 0;
        repeat (4) idleCycle();

        irqRandom = 1;
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < NDEV; i++) devData[i] = $urandom;
            loadDevData();
            byteA = 32'h7EC0 + (32'($urandom_range(0, 32'h9F)) & ~32'd3);
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
            applyStimulus(byteA[31:2], 1'($urandom), $urandom, 4'($urandom), w, 0, -1,
                          obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
            repeat ($urandom_range(0, 2)) idleCycle();
        end

        applyStimulus(30'h1FC0, 1'b0, 32'h0, 4'hF, 100, 0, 2, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        check("no ack after reset", 32'(obsAck), 32'hFFFF_FFFF);
        repeat (3) idleCycle();
        devData[1] = 32'hA5A5_0001;
        loadDevData();
        applyStimulus(30'h1FC5, 1'b0, 32'h0, 4'hF, 1, 0, -1, obsAck, obsErr, obsRd, obsSel1, obsAddr1, weCount);
        check("post reset ack cycle", 32'(obsAck), 32'd3);
        check("post reset data", obsRd, 32'hA5A5_0001);
        repeat (5) idleCycle();

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule

// File: doc/pr_bridge.md
# pr_bridge

Parametrised system bridge between the multi-cycle MIPS core's processor port and up to six memory-mapped peripherals. It decodes each request to one device and holds the request until that device signals ready or a timeout expires. It then returns read data with a one-cycle acknowledge and an error flag. It also synchronises device interrupt lines and presents them on the core's HWInt[7:2], with per-device level or edge capture.

## Interface
- NDEV, 4: number of devices; legal range 1..6.
- BASE, 32'h0000_7F00: byte address of device 0; must be aligned to 2^DEV_SPAN_LOG2.
- DEV_SPAN_LOG2, 4: log2 of the byte span per device; minimum 3.
- TIMEOUT, 15: maximum number of ACCESS cycles before an error; legal range 1..255.
- IRQ_EDGE, 0: NDEV-bit mask; bit i=1 selects edge capture for device i, 0 selects level.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- PrReq  in  1  request valid; sampled only in IDLE.
- PrWe  in  1  1 = write, 0 = read.
- PrAddr  in  30  word address [31:2].
- PrWD  in  32  write data.
- BE  in  4  byte enables.
- PrRD  out  32  registered read data; valid while PrAck=1.
- PrAck  out  1  one-cycle completion pulse.
- PrErr  out  1  qualifies PrAck: decode miss or timeout.
- DevSel  out  NDEV  one-hot device select.
- DevAddr  out  DEV_SPAN_LOG2-2  word offset within the selected device.
- DevWD  out  32  latched write data.
- DevBE  out  4  latched byte enables.
- DevWe  out  1  write strobe; asserted only together with DevSel.
- DevRD  in  NDEV*32  read data; device i on bits [32i+31:32i].
- DevRdy  in  NDEV  per-device ready.
- DevIrq  in  NDEV  asynchronous interrupt lines.
- HWInt  out  6  registered interrupt vector; bit k maps to core HWInt[k+2].

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE with PrReq=1: latch the request.
  - The full byte address is {PrAddr,2'b00}.
  - idx = (addr - BASE) >> DEV_SPAN_LOG2.
  - Hit when addr >= BASE and idx < NDEV.
  - On a hit: go to ACCESS, drive DevSel[idx]=1, and drive DevAddr/DevWD/DevBE/DevWe from the latched request.
  - On a miss: go to RESP with PrErr=1 and PrRD=0. No device is selected.
- ACCESS: device outputs are held stable.
  - cnt starts at 0 and increments each ACCESS cycle.
  - If DevRdy[idx]=1: capture DevRD[idx] into PrRD (writes capture 0) and go to RESP with PrErr=0.
  - Else if cnt==TIMEOUT-1: go to RESP with PrErr=1 and PrRD=0.
  - Ready takes priority over timeout in the same cycle.
  - DevRdy from unselected devices is ignored.
- RESP: PrAck=1 for exactly one cycle, DevSel=0, DevWe=0, then return to IDLE.
- PrReq in ACCESS or RESP is ignored. The core must not issue a new request before PrAck.
- Interrupts: each DevIrq passes through a 2-flop synchroniser to give s[i].
  - Level mode: pend[i] = s[i].
  - Edge mode: pend[i] is set on a 0→1 of s[i] and cleared on the RESP cycle of any non-error access to device i. If set and clear coincide, set wins.
- HWInt[i] = pend[i] for i<NDEV; bits at or above NDEV are tied to 0. HWInt is registered one cycle after pend.
- Reset: asserting rst mid-access returns to IDLE immediately, drops DevSel, and produces no PrAck.
- Reset value of every output register and all internal state (sync flops, pend, cnt) is 0: PrRD, PrAck, PrErr, DevSel, DevAddr, DevWD, DevBE, DevWe, HWInt.

## Timing
- Request in cycle 0 → ACCESS in cycle 1.
- Best case (DevRdy=1 in cycle 1): PrAck=1 in cycle 2.
- Each wait cycle adds one cycle of latency.
- Timeout: PrAck+PrErr in cycle TIMEOUT+1.
- Decode miss: PrAck+PrErr in cycle 1.
- Back-to-back: the earliest next request is the cycle after PrAck (RESP → IDLE).
- DevIrq edge to HWInt: 3 cycles level mode, 4 cycles edge mode (sync 2 + pend 1 + output 1).
- All outputs are registered; there is no combinational path from Pr* or Dev* inputs to any output.

## Test plan
- Read, device 1 ready immediately: PrAddr=30'h1FC4 (byte 0x7F10), PrWe=0, DevRdy[1]=1, DevRD[1]=32'hCAFEF00D → DevSel=4'b0010 in cycle 1; PrAck=1, PrErr=0, PrRD=32'hCAFEF00D in cycle 2.
- Write with 3 waits to device 2 (byte 0x7F24): BE=4'b0011, PrWD=32'h12345678 → DevAddr=1, DevWe=1 and DevBE=4'b0011 held for 4 cycles; PrAck in cycle 5.
- Timeout with TIMEOUT=15, DevRdy held at 0 → PrAck=1, PrErr=1, PrRD=0 in cycle 16. A second request is then serviced normally.
- Decode miss at byte 0x7F40 (NDEV=4) and at 0x7EFC → DevSel stays 0; PrAck+PrErr in cycle 1.
- IRQ_EDGE=4'b0100: a 1-cycle pulse on DevIrq[2] → HWInt[2] latches 4 cycles later. A completed read of device 2 clears it. A new edge in the RESP cycle keeps it set. Level DevIrq[0] follows the input with 3-cycle lag.
- rst low during ACCESS → all outputs 0 asynchronously and no PrAck. After release, a normal read completes.
